// File: rtl/prefix_query_gen.sv
// Expands an inclusive ID range [lo, hi] into signed per-digit-length prefix queries F(hi) - F(lo-1).
// Optional feature macro: AOC_QGEN_SKIP_D1_EN (suppress d=1 queries).
module prefix_query_gen #(
   parameter int MAX_DIGS   = 10,
   parameter int DATA_WIDTH = 40
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_range_valid,
   output logic                  o_range_ready,
   input  logic [DATA_WIDTH-1:0] i_range_lo,
   input  logic [DATA_WIDTH-1:0] i_range_hi,
   output logic                  o_q_valid,
   input  logic                  i_q_ready,
   output logic [DATA_WIDTH-1:0] o_q_n,
   output logic [3:0]            o_q_digs,
   output logic                  o_q_neg,
   output logic                  o_range_done,
   output logic                  o_range_err
);

`ifdef AOC_QGEN_SKIP_D1_EN
   localparam logic [3:0] E_FIRST = 4'd2;
`else
   localparam logic [3:0] E_FIRST = 4'd1;
`endif

   typedef enum logic [1:0] {IDLE, CNT, EMIT} state_t;

   function automatic logic [63:0] f_pow10(input int d);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < d; i++) p = p * 64'd10;
      return p;
   endfunction

   // Clip bound to the largest e-digit value.
   function automatic logic [DATA_WIDTH-1:0] f_clip(input logic [DATA_WIDTH-1:0] b,
                                                    input logic [63:0] pw);
      return (64'(b) < pw) ? b : DATA_WIDTH'(pw - 64'd1);
   endfunction

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_lo;
   logic [DATA_WIDTH-1:0] r_bound;
   logic                  r_phase_lo;
   logic [3:0]            r_d;
   logic [3:0]            r_digs;
   logic [3:0]            r_e;
   logic                  r_rdy;
   logic                  r_qv;
   logic [DATA_WIDTH-1:0] r_qn;
   logic [3:0]            r_qd;
   logic                  r_qneg;
   logic                  r_done;
   logic                  r_err;

   // Constant 10^d table, indexed by any 4-bit digit count.
   logic [63:0] w_pow [16];
   for (genvar g = 0; g < 16; g++) begin : g_pow
      assign w_pow[g] = f_pow10(g);
   end

   logic [3:0]            w_e_next;
   logic                  w_fits;
   logic                  w_last_d;
   logic                  w_more_lo;
   logic [DATA_WIDTH-1:0] w_n_first;
   logic [DATA_WIDTH-1:0] w_n_next;

   assign w_e_next  = r_e + 4'd1;
   assign w_fits    = 64'(r_bound) < w_pow[r_d];
   assign w_last_d  = (r_d == 4'(MAX_DIGS));
   assign w_more_lo = !r_phase_lo && (r_lo > DATA_WIDTH'(1));
   assign w_n_first = f_clip(r_bound, w_pow[E_FIRST]);
   assign w_n_next  = f_clip(r_bound, w_pow[w_e_next]);

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state    <= IDLE;
         r_lo       <= '0;
         r_bound    <= '0;
         r_phase_lo <= 1'b0;
         r_d        <= 4'd1;
         r_digs     <= 4'd1;
         r_e        <= 4'd1;
         r_rdy      <= 1'b0;
         r_qv       <= 1'b0;
         r_qn       <= '0;
         r_qd       <= 4'd0;
         r_qneg     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               r_rdy <= 1'b1;
               if (i_range_valid && r_rdy) begin
                  if (i_range_lo > i_range_hi) begin
                     r_err <= 1'b1;
                  end else begin
                     r_lo       <= i_range_lo;
                     r_bound    <= i_range_hi;
                     r_phase_lo <= 1'b0;
                     r_d        <= 4'd1;
                     r_rdy      <= 1'b0;
                     r_state    <= CNT;
                  end
               end
            end
            CNT: begin
               if (w_fits || w_last_d) begin
                  r_digs <= r_d;
                  if (E_FIRST > r_d) begin
                     // Phase has no queries: go straight to the next phase or finish.
                     if (w_more_lo) begin
                        r_bound    <= r_lo - DATA_WIDTH'(1);
                        r_phase_lo <= 1'b1;
                        r_d        <= 4'd1;
                     end else begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                        r_rdy   <= 1'b1;
                     end
                  end else begin
                     r_state <= EMIT;
                     r_e     <= E_FIRST;
                     r_qv    <= 1'b1;
                     r_qn    <= w_n_first;
                     r_qd    <= E_FIRST;
                     r_qneg  <= r_phase_lo;
                  end
               end else begin
                  r_d <= r_d + 4'd1;
               end
            end
            EMIT: begin
               if (i_q_ready) begin
                  if (r_e == r_digs) begin
                     r_qv <= 1'b0;
                     if (w_more_lo) begin
                        r_bound    <= r_lo - DATA_WIDTH'(1);
                        r_phase_lo <= 1'b1;
                        r_d        <= 4'd1;
                        r_state    <= CNT;
                     end else begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                        r_rdy   <= 1'b1;
                     end
                  end else begin
                     r_e  <= w_e_next;
                     r_qn <= w_n_next;
                     r_qd <= w_e_next;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_range_ready = r_rdy;
   assign o_q_valid     = r_qv;
   assign o_q_n         = r_qn;
   assign o_q_digs      = r_qd;
   assign o_q_neg       = r_qneg;
   assign o_range_done  = r_done;
   assign o_range_err   = r_err;

endmodule

// File: tb/tb_prefix_query_gen.sv
// Randomized bench for prefix_query_gen against a digit-arithmetic reference model.
module tb_prefix_query_gen;
   localparam int DW = 40;
   localparam int MD = 10;
`ifdef AOC_QGEN_SKIP_D1_EN
   localparam int E0 = 2;
`else
   localparam int E0 = 1;
`endif

   typedef struct {
      longint unsigned n;
      int              d;
      bit              neg;
   } q_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_range_valid = 1'b0;
   logic [DW-1:0] i_range_lo = '0;
   logic [DW-1:0] i_range_hi = '0;
   logic          i_q_ready = 1'b1;
   logic          o_range_ready, o_q_valid, o_q_neg, o_range_done, o_range_err;
   logic [DW-1:0] o_q_n;
   logic [3:0]    o_q_digs;

   int  n_chk = 0;
   int  n_pass = 0;
   q_t  exp_q[$];
   bit  exp_done = 0;
   bit  stall = 0;
   bit  rnd_rdy = 0;

   prefix_query_gen #(.MAX_DIGS(MD), .DATA_WIDTH(DW)) dut (
      .i_clock(clk), .i_reset(rst_n), .i_range_valid(i_range_valid), .o_range_ready(o_range_ready),
      .i_range_lo(i_range_lo), .i_range_hi(i_range_hi), .o_q_valid(o_q_valid), .i_q_ready(i_q_ready),
      .o_q_n(o_q_n), .o_q_digs(o_q_digs), .o_q_neg(o_q_neg),
      .o_range_done(o_range_done), .o_range_err(o_range_err));

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // ---- reference model ----
   function automatic longint unsigned p10(input int e);
      longint unsigned p = 1;
      for (int i = 0; i < e; i++) p = p * 10;
      return p;
   endfunction

   function automatic int ndig(input longint unsigned b);
      int n = 1;
      while (b >= 10) begin b = b / 10; n++; end
      return (n > MD) ? MD : n;
   endfunction

   task automatic push_phase(input longint unsigned b, input bit neg);
      q_t q;
      for (int e = E0; e <= ndig(b); e++) begin
         q.n   = (b < p10(e)) ? b : p10(e) - 1;
         q.d   = e;
         q.neg = neg;
         exp_q.push_back(q);
      end
   endtask

   task automatic model_range(input longint unsigned lo, input longint unsigned hi);
      if (lo > hi) return;
      push_phase(hi, 1'b0);
      if (lo >= 2) push_phase(lo - 1, 1'b1);
   endtask

   // ---- q_ready driver ----
   always @(posedge clk) begin
      #1;
      i_q_ready = stall ? 1'b0 : (rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
   end

   // ---- compare process ----
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_done = 0;
      end else begin
         if (exp_done) begin
            chk("done_after_last", o_range_done, 1);
            exp_done = 0;
         end else if (o_range_done) begin
            chk("done_early_queries_left", exp_q.size(), 0);
         end
         if (o_q_valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_q_valid", o_q_valid, 0);
            end else begin
               chk("q_n", o_q_n, exp_q[0].n);
               chk("q_digs", o_q_digs, exp_q[0].d);
               chk("q_neg", o_q_neg, exp_q[0].neg);
               if (i_q_ready) begin
                  void'(exp_q.pop_front());
                  if (exp_q.size() == 0) exp_done = 1;
               end
            end
         end
      end
   end

   task automatic send(input longint unsigned lo, input longint unsigned hi);
      int t = 0;
      @(negedge clk);
      while (!o_range_ready && t < 300) begin @(negedge clk); t++; end
      chk("range_ready_wait", o_range_ready, 1);
      i_range_lo    = DW'(lo);
      i_range_hi    = DW'(hi);
      i_range_valid = 1'b1;
      model_range(lo, hi);
      @(posedge clk);
      #1 i_range_valid = 1'b0;
   endtask

   task automatic wait_end(input bit exp_err);
      int t = 0;
      @(negedge clk);
      while (!(o_range_err || o_range_done) && t < 600) begin @(negedge clk); t++; end
      chk("end_err", o_range_err, exp_err);
      chk("end_done", o_range_done, !exp_err);
      @(negedge clk);
      chk("err_pulse_width", o_range_err, 0);
      chk("done_pulse_width", o_range_done, 0);
      chk("ready_after_end", o_range_ready, 1);
      chk("queue_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic run(input longint unsigned lo, input longint unsigned hi);
      send(lo, hi);
      wait_end(lo > hi);
   endtask

   initial begin
      #4_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      longint unsigned lo, hi, r;
      int t;

      // pin the model with hand-computed streams
      model_range(11, 22);
`ifdef AOC_QGEN_SKIP_D1_EN
      chk("model_c1_size", exp_q.size(), 2);
      chk("model_c1_0n", exp_q[0].n, 22); chk("model_c1_0d", exp_q[0].d, 2);
      chk("model_c1_1n", exp_q[1].n, 10); chk("model_c1_1neg", exp_q[1].neg, 1);
      exp_q.delete();
      model_range(3, 7);
      chk("model_3_7_size", exp_q.size(), 0);
`else
      chk("model_c1_size", exp_q.size(), 4);
      chk("model_c1_0n", exp_q[0].n, 9);  chk("model_c1_0d", exp_q[0].d, 1);
      chk("model_c1_1n", exp_q[1].n, 22); chk("model_c1_1d", exp_q[1].d, 2);
      chk("model_c1_2n", exp_q[2].n, 9);  chk("model_c1_2neg", exp_q[2].neg, 1);
      chk("model_c1_3n", exp_q[3].n, 10); chk("model_c1_3neg", exp_q[3].neg, 1);
`endif
      exp_q.delete();
      model_range(5, 64'hFF_FFFF_FFFF);
      chk("model_sat_size", exp_q.size(), 10 - E0 + 1 + 1 - E0 + 1 - ((E0 == 2) ? 0 : 0));
      chk("model_sat_last", exp_q[10 - E0].n, 64'd9_999_999_999);
      exp_q.delete();

      // reset state
      #1;
      chk("rst_q_valid", o_q_valid, 0);
      chk("rst_done", o_range_done, 0);
      chk("rst_err", o_range_err, 0);
      chk("rst_ready", o_range_ready, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("ready_after_rst", o_range_ready, 1);

      run(11, 22);                    // case 1
      run(1, 99);                     // case 2
      run(50, 40);                    // case 4
      run(3, 7);
      run(0, 5);
      run(5, 64'hFF_FFFF_FFFF);       // saturation at MAX_DIGS

      // case 3: stall while the second query is presented
      send(11, 22);
      t = 0;
      while (!o_q_valid && t < 100) begin @(negedge clk); t++; end
      stall = 1;
      repeat (3) begin
         @(negedge clk);
         chk("stall_valid", o_q_valid, 1);
`ifdef AOC_QGEN_SKIP_D1_EN
         chk("stall_hold_n", o_q_n, 10);
`else
         chk("stall_hold_n", o_q_n, 22);
`endif
      end
      stall = 0;
      wait_end(0);

      // case 5: reset during EMIT
      send(11, 22);
      t = 0;
      while (!o_q_valid && t < 100) begin @(negedge clk); t++; end
      rst_n = 1'b0;
      #1;
      chk("midrst_q_valid", o_q_valid, 0);
      chk("midrst_done", o_range_done, 0);
      chk("midrst_ready", o_range_ready, 0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      chk("midrst_no_done", o_range_done, 0);
      rst_n = 1'b1;
      run(1, 99);

      // randomized ranges with random backpressure
      rnd_rdy = 1;
      for (int k = 0; k < 150; k++) begin
         r  = {$urandom, $urandom};
         hi = r % p10($urandom_range(1, 12));
         case ($urandom_range(0, 9))
            0:       lo = $urandom_range(0, 1);
            1:       lo = hi + $urandom_range(1, 1000);
            default: lo = (hi == 0) ? 0 : ({$urandom, $urandom} % (hi + 1));
         endcase
         run(lo, hi);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
